// File: rtl/counters_pkg.sv
// Shared types and constants for the timing/counter library.
package counters_pkg;

    localparam int unsigned DEFAULT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cnt_state_t;

endpackage

// File: rtl/down_counter_ld.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Terminal count is reached at count_out==1; tc_pulse marks the reload/finish edge.
module down_counter_ld
    import counters_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] eff_rv;

    // A load in the same cycle bypasses the reload register.
    assign eff_rv = load ? load_value : reload_q;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = load ? load_value : reload_q;
        tc_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    count_d = load_value;
                end
                if (start && !stop) begin
                    count_d = eff_rv;
                    if (eff_rv == '0) begin
                        state_d = DONE;
                        tc_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (enable) begin
                    if (count_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = eff_rv;
                            if (eff_rv == '0) begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end

            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    count_d = eff_rv;
                    if (eff_rv == '0) begin
                        tc_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign count_out = count_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign tc_pulse  = tc_q;

endmodule

// File: tb/tb_down_counter_ld.sv
// Directed self-checking bench for down_counter_ld (WIDTH=4).
module tb_down_counter_ld;

    logic       clock;
    logic       reset_L;
    logic       load;
    logic [3:0] load_value;
    logic       start;
    logic       stop;
    logic       enable;
    logic       auto_reload;
    logic [3:0] count_out;
    logic       busy;
    logic       done;
    logic       tc_pulse;

    int unsigned checks = 0;
    int unsigned errors = 0;

    down_counter_ld #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count_out   (count_out),
        .busy        (busy),
        .done        (done),
        .tc_pulse    (tc_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] c, input logic b,
                           input logic d, input logic t);
        chk({tag, ".count"}, 32'(count_out), 32'(c));
        chk({tag, ".busy"},  32'(busy),      32'(b));
        chk({tag, ".done"},  32'(done),      32'(d));
        chk({tag, ".tc"},    32'(tc_pulse),  32'(t));
    endtask

    initial begin
        logic [3:0] e;

        reset_L = 1'b0; load = 1'b0; load_value = '0; start = 1'b0;
        stop = 1'b0; enable = 1'b0; auto_reload = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        reset_L = 1'b1;
        tick();

        // One-shot 3,2,1,0
        load = 1'b1; load_value = 4'd3;
        tick();
        load = 1'b0;
        chk_all("os_load", 4'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        chk_all("os_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("os_c2", 4'd2, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("os_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("os_c0", 4'd0, 1'b0, 1'b1, 1'b1);
        tick(); chk_all("os_hold", 4'd0, 1'b0, 1'b1, 1'b0);

        // Auto-reload period 4
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("ar_stop", 4'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_value = 4'd4; auto_reload = 1'b1;
        tick();
        load = 1'b0;
        chk_all("ar_load", 4'd4, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ar_start", 4'd4, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            tick();
            e = 4'(4 - ((k + 1) % 4));
            chk_all("ar_seq", e, 1'b1, 1'b0, (e == 4'd4));
        end
        // count is 1 here: stop must beat the terminal count
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("ar_stop_tc", 4'd1, 1'b0, 1'b0, 1'b0);

        // Pause, start-in-RUN, mid-run reload
        load = 1'b1; load_value = 4'd5;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("pr_c5", 4'd5, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("pr_c4", 4'd4, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("pr_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all("pr_pause", 4'd3, 1'b1, 1'b0, 1'b0);
        end
        enable = 1'b1; load = 1'b1; load_value = 4'd2;
        tick();
        load = 1'b0;
        chk_all("pr_ld_run", 4'd2, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("pr_start_ign", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("pr_rl2", 4'd2, 1'b1, 1'b0, 1'b1);
        tick(); chk_all("pr_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("pr_rl2b", 4'd2, 1'b1, 1'b0, 1'b1);

        // Zero reload and full-scale one-shot
        stop = 1'b1;
        tick();
        stop = 1'b0;
        auto_reload = 1'b0;
        load = 1'b1; load_value = 4'd0;
        tick();
        load = 1'b0;
        chk_all("z_load", 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("z_start", 4'd0, 1'b0, 1'b1, 1'b1);
        tick(); chk_all("z_hold", 4'd0, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_value = 4'hF; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        chk_all("f_start", 4'hF, 1'b1, 1'b0, 1'b0);
        for (int k = 14; k >= 1; k--) begin
            tick();
            chk_all("f_seq", 4'(k), 1'b1, 1'b0, 1'b0);
        end
        tick(); chk_all("f_tc", 4'd0, 1'b0, 1'b1, 1'b1);

        // Stop priority
        stop = 1'b1;
        tick();
        chk_all("sp_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk_all("sp_both", 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("sp_run", 4'hF, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) tick();
        chk_all("sp_at2", 4'd2, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("sp_stop2", 4'd2, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("sp_idle2", 4'd2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-count
        load = 1'b1; load_value = 4'd6;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ar6_start", 4'd6, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("ar6_c4", 4'd4, 1'b1, 1'b0, 1'b0);
        #2 reset_L = 1'b0;
        #1 chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        #2 reset_L = 1'b1;
        tick();
        tick();
        chk_all("post_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        // reload register was cleared, so a bare start finishes immediately
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("post_rst_start", 4'd0, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
